// File: rtl/raster_pkg.sv
// Shared types for the raster scheduler slice.
//   MODEL_W       : model word width, matches rasterize model_in
//   PIXEL_W       : rasterizer pixel coordinate width
//   model_t       : one model word
//   sched_state_t : dispatch FSM states
package raster_pkg;

    localparam int unsigned MODEL_W = 55;
    localparam int unsigned PIXEL_W = 31;

    typedef logic [MODEL_W-1:0] model_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/raster_scheduler_if.sv
// Producer and rasterizer handshake bundle for raster_scheduler.
//   req_valid/req_model/req_ready : per-requester model submission
//   frame_start                   : flush + clear statistics pulse
//   raster_valid/raster_model     : issue strobe and held model to rasterize
//   raster_done                   : rasterizer completion pulse
//   busy/timeout_err/tri_count    : status and per-frame statistics
// master = environment side, slave = scheduler side.
interface raster_scheduler_if
    import raster_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
);

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*MODEL_W-1:0] req_model;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       frame_start;
    logic                       raster_valid;
    model_t                     raster_model;
    logic                       raster_done;
    logic                       busy;
    logic                       timeout_err;
    logic [15:0]                tri_count;

    modport master (
        output req_valid, req_model, frame_start, raster_done,
        input  req_ready, raster_valid, raster_model, busy, timeout_err, tri_count
    );

    modport slave (
        input  req_valid, req_model, frame_start, raster_done,
        output req_ready, raster_valid, raster_model, busy, timeout_err, tri_count
    );

endinterface

// File: rtl/raster_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above pointer, with wrap.
//   req       : request vector
//   enable    : when low no grant is issued
//   pointer   : highest-priority index this cycle
//   grant     : one-hot grant (all zero when nothing granted)
//   grant_idx : index of the granted requester (0 when nothing granted)
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    input  logic [IDX_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic             found;
    logic [IDX_W-1:0] cur;

    // Scan NUM_REQ positions starting at pointer; first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cur       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cur = IDX_W'((32'(pointer) + k) % NUM_REQ);
            if (enable && !found && req[cur]) begin
                found      = 1'b1;
                grant[cur] = 1'b1;
                grant_idx  = cur;
            end
        end
    end

endmodule

// File: rtl/raster_scheduler.sv
// Front-end controller for rasterize: round-robin intake into a small FIFO and
// a dispatch FSM that issues one model at a time, waiting for raster_done or a timeout.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : raster_scheduler_if.slave (requesters, rasterizer, status)
module raster_scheduler
    import raster_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic               clk,
    input  logic               rst,
    raster_scheduler_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);

    sched_state_t     state, state_d;
    model_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic [IDX_W-1:0] rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic [TMO_W-1:0] tmo_cnt;
    model_t           model_q;
    logic [15:0]      tri_q;
    logic             terr_q;
    logic             fifo_full, arb_en, push, pop, issue, tmo_inc, tmo_hit;
    model_t           push_data;

    assign fifo_full = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    // Reset gating keeps req_ready low while rst is held.
    assign arb_en    = !rst && !fifo_full && !bus.frame_start;
    assign push      = |grant;
    assign push_data = bus.req_model[32'(grant_idx)*MODEL_W +: MODEL_W];

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (bus.req_valid),
        .enable    (arb_en),
        .pointer   (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Round-robin pointer moves past the winner on each transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  rr_ptr <= '0;
        else if (bus.frame_start) rr_ptr <= '0;
        else if (push)            rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end

    // FIFO storage (data only, no reset needed).
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // FIFO pointers and occupancy; power-of-2 depth wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (bus.frame_start) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // FSM next state and action strobes; frame_start overrides everything.
    always_comb begin
        state_d = state;
        pop     = 1'b0;
        issue   = 1'b0;
        tmo_inc = 1'b0;
        tmo_hit = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_cnt != '0) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                issue   = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.raster_done) begin
                    state_d = IDLE;
                end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                    tmo_hit = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.frame_start) begin
            state_d = IDLE;
            pop     = 1'b0;
            issue   = 1'b0;
            tmo_hit = 1'b0;
        end
    end

    // Datapath registers: issued model, wait counter, statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            model_q <= '0;
            tmo_cnt <= '0;
            tri_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            if (pop) model_q <= mem[rd_ptr];
            if (issue)        tmo_cnt <= '0;
            else if (tmo_inc) tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (bus.frame_start)             tri_q <= '0;
            else if (issue && tri_q != 16'hFFFF) tri_q <= tri_q + 16'd1;
            if (bus.frame_start) terr_q <= 1'b0;
            else if (tmo_hit)    terr_q <= 1'b1;
        end
    end

    assign bus.req_ready    = grant;
    assign bus.raster_valid = (state == ISSUE);
    assign bus.raster_model = model_q;
    assign bus.busy         = (state != IDLE) || (fifo_cnt != '0);
    assign bus.timeout_err  = terr_q;
    assign bus.tri_count    = tri_q;

endmodule

// File: tb/tb_raster_scheduler.sv
// Randomized self-checking bench for raster_scheduler against a queue-based reference model.
module tb_raster_scheduler;
    import raster_pkg::*;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    raster_scheduler_if #(.NUM_REQ(NREQ)) bus ();

    raster_scheduler #(
        .NUM_REQ     (NREQ),
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    model_t mdl [NREQ];

    // Reference model: pending queue plus a simple dispatch phase
    model_t q[$];
    int     m_ptr, m_age, m_tri;
    bit     m_issuing, m_waiting, m_terr;
    model_t m_model;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic model_t rand_model();
        logic [63:0] w;
        w = {$urandom(), $urandom()};
        return w[MODEL_W-1:0];
    endfunction

    task automatic drive_models();
        for (int i = 0; i < NREQ; i++) bus.req_model[i*MODEL_W +: MODEL_W] = mdl[i];
    endtask

    task automatic m_reset();
        q.delete();
        m_ptr = 0; m_age = 0; m_tri = 0;
        m_issuing = 0; m_waiting = 0; m_terr = 0;
        m_model = '0;
    endtask

    function automatic int exp_grant();
        if (rst || bus.frame_start || q.size() >= DEPTH) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (bus.req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int g);
        logic [NREQ-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // One clock: check all outputs against the model, advance the model, step to posedge+1.
    task automatic cycle();
        int g;
        #1;
        g = exp_grant();
        chk("req_ready",    64'(bus.req_ready),    64'(onehot(g)));
        chk("raster_valid", 64'(bus.raster_valid), 64'(m_issuing));
        chk("raster_model", 64'(bus.raster_model), 64'(m_model));
        chk("busy",         64'(bus.busy),         64'(m_issuing || m_waiting || q.size() != 0));
        chk("timeout_err",  64'(bus.timeout_err),  64'(m_terr));
        chk("tri_count",    64'(bus.tri_count),    64'(m_tri));
        if (!rst) begin
            if (bus.frame_start) begin
                q.delete();
                m_issuing = 0; m_waiting = 0;
                m_ptr = 0; m_tri = 0; m_terr = 0;
            end else begin
                if (m_issuing) begin
                    m_issuing = 0; m_waiting = 1; m_age = 0;
                    if (m_tri < 65535) m_tri++;
                end else if (m_waiting) begin
                    if (bus.raster_done) m_waiting = 0;
                    else if (m_age == TMO - 1) begin m_waiting = 0; m_terr = 1; end
                    else m_age++;
                end else if (q.size() > 0) begin
                    m_model = q.pop_front();
                    m_issuing = 1;
                end
                if (g >= 0) begin
                    q.push_back(mdl[g]);
                    m_ptr = (g + 1) % NREQ;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame_start();
        bus.frame_start = 1'b1;
        cycle();
        bus.frame_start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int gq[$];
        model_t iq[$];
        int since, rv_cnt;

        rst = 1'b1;
        bus.req_valid = '0; bus.req_model = '0;
        bus.frame_start = 1'b0; bus.raster_done = 1'b0;
        for (int i = 0; i < NREQ; i++) mdl[i] = rand_model();
        drive_models();
        m_reset();
        @(posedge clk); #1;
        bus.req_valid = 4'b1111;   // no grant may appear while in reset
        repeat (2) cycle();
        bus.req_valid = '0;
        rst = 1'b0;

        // Single request: issue two cycles after transfer
        mdl[0] = 55'h0000_5F82_0810_03;
        drive_models();
        bus.req_valid = 4'b0001;
        cycle();
        bus.req_valid = '0;
        cycle();
        #1;
        chk("single_valid_c2", 64'(bus.raster_valid), 64'd1);
        chk("single_model",    64'(bus.raster_model), 64'h0000_5F82_0810_03);
        cycle();
        #1;
        chk("single_tri", 64'(bus.tri_count), 64'd1);
        repeat (3) cycle();
        #1;
        chk("single_busy_wait", 64'(bus.busy), 64'd1);
        bus.raster_done = 1'b1;
        cycle();
        bus.raster_done = 1'b0;
        #1;
        chk("single_idle_busy", 64'(bus.busy), 64'd0);

        // Round-robin fairness with raster_done five cycles after each issue
        pulse_frame_start();
        for (int i = 0; i < NREQ; i++) mdl[i] = rand_model();
        drive_models();
        bus.req_valid = 4'b1111;
        since = 100;
        for (int c = 0; c < 80; c++) begin
            bus.raster_done = (since == 5);
            #1;
            if (bus.req_ready != '0) gq.push_back($clog2(bus.req_ready));
            if (bus.raster_valid) begin iq.push_back(bus.raster_model); since = 0; end
            else since++;
            cycle();
        end
        bus.raster_done = 1'b0;
        bus.req_valid = '0;
        chk("rr_enough", 64'(gq.size() >= 8 && iq.size() >= 8), 64'd1);
        for (int k = 0; k < 8; k++) begin
            if (k < gq.size()) chk("rr_grant", 64'(gq[k]), 64'(k % NREQ));
            if (k < iq.size()) chk("rr_issue", 64'(iq[k]), 64'(mdl[k % NREQ]));
        end

        // FIFO full: one in WAIT plus DEPTH queued, then no grants
        pulse_frame_start();
        bus.req_valid = 4'b1111;
        rv_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus.raster_valid) rv_cnt++;
            cycle();
        end
        #1;
        chk("full_ready",  64'(bus.req_ready), 64'd0);
        chk("full_issues", 64'(rv_cnt), 64'd1);
        bus.req_valid = '0;

        // Timeout: wait expires, sticky error, next model issues, late done ignored
        for (int c = 0; c < 30 && m_waiting; c++) cycle();
        #1;
        chk("tmo_err_set", 64'(bus.timeout_err), 64'd1);
        chk("tmo_idle_rv", 64'(bus.raster_valid), 64'd0);
        bus.raster_done = 1'b1;
        cycle();
        bus.raster_done = 1'b0;
        #1;
        chk("tmo_next_issue", 64'(bus.raster_valid), 64'd1);
        repeat (3) cycle();
        #1;
        chk("tmo_err_sticky", 64'(bus.timeout_err), 64'd1);
        chk("tmo_tri",        64'(bus.tri_count), 64'd2);

        // frame_start mid-WAIT with three queued
        pulse_frame_start();
        #1;
        chk("fs_busy", 64'(bus.busy), 64'd0);
        chk("fs_tri",  64'(bus.tri_count), 64'd0);
        chk("fs_terr", 64'(bus.timeout_err), 64'd0);
        rv_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            bus.raster_done = (c == 2);
            #1;
            if (bus.raster_valid) rv_cnt++;
            cycle();
        end
        bus.raster_done = 1'b0;
        chk("fs_no_issue", 64'(rv_cnt), 64'd0);

        // Asynchronous reset in the middle of an ISSUE cycle
        bus.req_valid = 4'b0001;
        cycle();
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 6 && !m_issuing; c++) cycle();
        #1;
        chk("ar_pre_valid", 64'(bus.raster_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("ar_valid", 64'(bus.raster_valid), 64'd0);
        chk("ar_ready", 64'(bus.req_ready), 64'd0);
        chk("ar_tri",   64'(bus.tri_count), 64'd0);
        chk("ar_busy",  64'(bus.busy), 64'd0);
        bus.req_valid = '0;
        m_reset();
        @(posedge clk); #1;
        rst = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                for (int i = 0; i < NREQ; i++) mdl[i] = rand_model();
                drive_models();
            end
            bus.req_valid   = (c % 600 < 300) ? 4'($urandom()) : 4'($urandom() & $urandom());
            bus.raster_done = ($urandom_range(0, 11) == 0);
            bus.frame_start = ($urandom_range(0, 249) == 0);
            cycle();
        end
        bus.req_valid = '0; bus.raster_done = 1'b0; bus.frame_start = 1'b0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
